// File: rtl/axil2wb_bridge.sv
// AXI4-Lite slave to Wishbone classic master bridge.
// One transaction in flight at a time. Read/write priority alternates after
// each completed transfer. wb_err_i is reported to AXI as SLVERR.
// Optional macro AXIL2WB_TIMEOUT_EN adds a watchdog. If the Wishbone slave
// never answers, the watchdog ends the cycle and reports SLVERR.
module axil2wb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [31:0]           wb_dat_o,
    output logic [3:0]            wb_sel_o,
    output logic                  wb_we_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i
);

    typedef enum logic [2:0] {IDLE, WB_WR, WB_RD, BRESP, RRESP} state_t;

    state_t                state_q;
    logic                  aw_held_q, w_held_q, prio_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;

    logic [ADDR_WIDTH-1:0] wb_adr_q;
    logic [31:0]           wb_dat_q;
    logic [3:0]            wb_sel_q;
    logic                  wb_we_q, wb_cyc_q, wb_stb_q;
    logic                  bvalid_q, rvalid_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [31:0]           rdata_q;

    logic in_idle, rd_grant, aw_hs, w_hs, wr_go;
    logic tmo_hit, wb_fail, wb_done;

    // Readies exist only in IDLE. They are held low during reset so that
    // every output reads 0 while rst_i is high.
    assign in_idle  = (state_q == IDLE) && !rst_i;
    assign rd_grant = in_idle && !aw_held_q && !w_held_q && s_axi_arvalid &&
                      (prio_q || !(s_axi_awvalid || s_axi_wvalid));

    assign s_axi_awready = in_idle && !aw_held_q && !rd_grant;
    assign s_axi_wready  = in_idle && !w_held_q && !rd_grant;
    assign s_axi_arready = rd_grant;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    // A write can start once both halves are held or arrive in this cycle.
    assign wr_go = (aw_held_q || aw_hs) && (w_held_q || w_hs);

`ifdef AXIL2WB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    // Watchdog: count strobe cycles that get no answer. The count clears
    // whenever the strobe is low, so each new Wishbone cycle starts at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i || !wb_stb_q)
            tmo_cnt_q <= '0;
        else if (!(wb_ack_i || wb_err_i))
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end

    // If ack arrives in the same cycle that the count expires, ack wins.
    assign tmo_hit = wb_stb_q && !(wb_ack_i || wb_err_i) &&
                     (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Asserting ack and err together counts as an error.
    assign wb_fail = wb_err_i || tmo_hit;
    assign wb_done = wb_ack_i || wb_fail;

    // Main control FSM. All bus outputs are registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            prio_q    <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wb_adr_q  <= '0;
            wb_dat_q  <= '0;
            wb_sel_q  <= '0;
            wb_we_q   <= 1'b0;
            wb_cyc_q  <= 1'b0;
            wb_stb_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        aw_held_q <= 1'b1;
                        awaddr_q  <= s_axi_awaddr;
                    end
                    if (w_hs) begin
                        w_held_q <= 1'b1;
                        wdata_q  <= s_axi_wdata;
                        wstrb_q  <= s_axi_wstrb;
                    end
                    if (wr_go) begin
                        state_q  <= WB_WR;
                        wb_cyc_q <= 1'b1;
                        wb_stb_q <= 1'b1;
                        wb_we_q  <= 1'b1;
                        wb_adr_q <= aw_hs ? s_axi_awaddr : awaddr_q;
                        wb_dat_q <= w_hs ? s_axi_wdata : wdata_q;
                        wb_sel_q <= w_hs ? s_axi_wstrb : wstrb_q;
                    end else if (rd_grant) begin
                        state_q  <= WB_RD;
                        wb_cyc_q <= 1'b1;
                        wb_stb_q <= 1'b1;
                        wb_we_q  <= 1'b0;
                        wb_adr_q <= s_axi_araddr;
                        wb_sel_q <= 4'hF;
                    end
                end
                WB_WR: begin
                    if (wb_done) begin
                        wb_cyc_q <= 1'b0;
                        wb_stb_q <= 1'b0;
                        wb_we_q  <= 1'b0;
                        bresp_q  <= wb_fail ? 2'b10 : 2'b00;
                        bvalid_q <= 1'b1;
                        state_q  <= BRESP;
                    end
                end
                WB_RD: begin
                    if (wb_done) begin
                        wb_cyc_q <= 1'b0;
                        wb_stb_q <= 1'b0;
                        rdata_q  <= wb_fail ? 32'h0 : wb_dat_i;
                        rresp_q  <= wb_fail ? 2'b10 : 2'b00;
                        rvalid_q <= 1'b1;
                        state_q  <= RRESP;
                    end
                end
                BRESP: begin
                    if (s_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        prio_q    <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                RRESP: begin
                    if (s_axi_rready) begin
                        rvalid_q <= 1'b0;
                        prio_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_adr_o     = wb_adr_q;
    assign wb_dat_o     = wb_dat_q;
    assign wb_sel_o     = wb_sel_q;
    assign wb_we_o      = wb_we_q;
    assign wb_cyc_o     = wb_cyc_q;
    assign wb_stb_o     = wb_stb_q;
    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rdata  = rdata_q;

endmodule

// File: tb/tb_axil2wb_bridge.sv
// Scoreboard bench for axil2wb_bridge. A behavioural Wishbone slave answers
// the bridge. Monitors pop the expected Wishbone cycles and AXI responses.
module tb_axil2wb_bridge;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [AW-1:0] s_axi_awaddr, s_axi_araddr, wb_adr_o;
    logic          s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [31:0]   s_axi_wdata, s_axi_rdata, wb_dat_o, wb_dat_i;
    logic [3:0]    s_axi_wstrb, wb_sel_o;
    logic [1:0]    s_axi_bresp, s_axi_rresp;
    logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic          s_axi_rvalid, s_axi_rready;
    logic          wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;

    always #5 clk = ~clk;

    axil2wb_bridge #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          len;   // expected strobe cycles
    } wb_exp_t;
    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_exp_t;

    wb_exp_t  exp_wb[$];
    rsp_exp_t exp_b[$], exp_r[$];
    wb_exp_t  me;
    rsp_exp_t mr;
    int vectors = 0, miscompares = 0;

    int          sl_wait = 0, sl_cnt = 0;
    bit          sl_err = 0, sl_silent = 0;
    logic [31:0] sl_rdata = 32'h0;

    // Wishbone slave: answers after sl_wait extra strobe cycles.
    initial begin
        wb_ack_i = 0; wb_err_i = 0; wb_dat_i = 0;
        forever begin
            @(negedge clk);
            if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
                if (!sl_silent && sl_cnt == sl_wait) begin
                    wb_ack_i = !sl_err; wb_err_i = sl_err; wb_dat_i = sl_rdata;
                end else sl_cnt++;
            end else begin
                wb_ack_i = 0; wb_err_i = 0; wb_dat_i = 0; sl_cnt = 0;
            end
        end
    end

    // Monitor: scoreboard pops on each Wishbone termination and AXI response.
    int stb_len = 0;
    initial begin
        forever begin
            @(negedge clk); #2;
            if (wb_stb_o) begin
                stb_len++;
                if (wb_ack_i || wb_err_i) begin
                    vectors++;
                    if (exp_wb.size() == 0) begin
                        miscompares++;
                        $display("FAIL wb_unexpected: adr=%h we=%b", wb_adr_o, wb_we_o);
                    end else begin
                        me = exp_wb.pop_front();
                        if ({wb_we_o, wb_adr_o, wb_sel_o} !== {me.we, me.adr, me.sel} ||
                            (me.we && wb_dat_o !== me.dat) || stb_len != me.len) begin
                            miscompares++;
                            $display("FAIL wb_cycle: got we=%b adr=%h dat=%h sel=%h len=%0d, want we=%b adr=%h dat=%h sel=%h len=%0d",
                                     wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, stb_len,
                                     me.we, me.adr, me.dat, me.sel, me.len);
                        end
                    end
                end
            end else stb_len = 0;
            if (s_axi_bvalid && s_axi_bready) begin
                vectors++;
                if (exp_b.size() == 0) begin
                    miscompares++; $display("FAIL b_unexpected: bresp=%b", s_axi_bresp);
                end else begin
                    mr = exp_b.pop_front();
                    if (s_axi_bresp !== mr.resp) begin
                        miscompares++; $display("FAIL bresp: got %b want %b", s_axi_bresp, mr.resp);
                    end
                end
            end
            if (s_axi_rvalid && s_axi_rready) begin
                vectors++;
                if (exp_r.size() == 0) begin
                    miscompares++; $display("FAIL r_unexpected: rdata=%h", s_axi_rdata);
                end else begin
                    mr = exp_r.pop_front();
                    if ({s_axi_rresp, s_axi_rdata} !== {mr.resp, mr.data}) begin
                        miscompares++;
                        $display("FAIL rresp: got %b/%h want %b/%h", s_axi_rresp, s_axi_rdata, mr.resp, mr.data);
                    end
                end
            end
        end
    end

    function automatic wb_exp_t mk_wb(logic we, logic [31:0] adr, logic [31:0] dat, logic [3:0] sel, int len);
        wb_exp_t e;
        e.we = we; e.adr = adr; e.dat = dat; e.sel = sel; e.len = len;
        return e;
    endfunction

    function automatic rsp_exp_t mk_rsp(logic [1:0] resp, logic [31:0] data);
        rsp_exp_t e;
        e.resp = resp; e.data = data;
        return e;
    endfunction

    // The AXI driver tasks below start and end on a negedge.
    task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_done = 0, w_done = 0;
        int n = 0;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        while (!(aw_done && w_done) && n < 100) begin
            #1;
            if (s_axi_awvalid && s_axi_awready) aw_done = 1;
            if (s_axi_wvalid && s_axi_wready) w_done = 1;
            @(negedge clk); n++;
            if (aw_done) s_axi_awvalid = 0;
            if (w_done) s_axi_wvalid = 0;
        end
        if (n >= 100) begin
            vectors++; miscompares++;
            $display("FAIL aw_w_handshake: timed out, want accept");
            s_axi_awvalid = 0; s_axi_wvalid = 0;
        end
    endtask

    task automatic axi_rd(input logic [31:0] a);
        bit done = 0;
        int n = 0;
        s_axi_araddr = a; s_axi_arvalid = 1;
        while (!done && n < 100) begin
            #1;
            if (s_axi_arready) done = 1;
            @(negedge clk); n++;
        end
        s_axi_arvalid = 0;
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL ar_handshake: timed out, want accept");
        end
    endtask

    task automatic wait_b();
        int n = 0;
        s_axi_bready = 1; #1;
        while (!s_axi_bvalid && n < 100) begin @(negedge clk); #1; n++; end
        if (n >= 100) begin
            vectors++; miscompares++; $display("FAIL bvalid_wait: timed out, want bvalid");
        end
        @(negedge clk); s_axi_bready = 0;
    endtask

    task automatic wait_r();
        int n = 0;
        s_axi_rready = 1; #1;
        while (!s_axi_rvalid && n < 100) begin @(negedge clk); #1; n++; end
        if (n >= 100) begin
            vectors++; miscompares++; $display("FAIL rvalid_wait: timed out, want rvalid");
        end
        @(negedge clk); s_axi_rready = 0;
    endtask

    task automatic test_reset();
        rst_i = 1;
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
        s_axi_bready = 0; s_axi_rready = 0;
        s_axi_awaddr = 0; s_axi_araddr = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, s_axi_bresp,
             s_axi_rresp, s_axi_rdata, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o} !== '0) begin
            miscompares++; $display("FAIL reset_outputs: got nonzero, want all 0");
        end
        @(negedge clk); rst_i = 0; #1;
        vectors++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b110) begin
            miscompares++;
            $display("FAIL idle_readies: got %b want 110", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
        @(negedge clk);
    endtask

    task automatic test_write();
        sl_wait = 0; sl_err = 0; sl_silent = 0;
        exp_wb.push_back(mk_wb(1, 32'h10, 32'hA5A5A5A5, 4'hF, 1));
        exp_b.push_back(mk_rsp(2'b00, 0));
        axi_wr(32'h10, 32'hA5A5A5A5, 4'hF);
        #1; vectors++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b111) begin
            miscompares++; $display("FAIL wr_stb_latency: got %b want 111", {wb_cyc_o, wb_stb_o, wb_we_o});
        end
        @(negedge clk); #1; vectors++;
        if ({wb_stb_o, wb_we_o, s_axi_bvalid} !== 3'b001) begin
            miscompares++; $display("FAIL wr_bvalid_latency: got %b want 001", {wb_stb_o, wb_we_o, s_axi_bvalid});
        end
        wait_b();
    endtask

    task automatic test_split_write();
        exp_wb.push_back(mk_wb(1, 32'h20, 32'h11223344, 4'h3, 1));
        exp_b.push_back(mk_rsp(2'b00, 0));
        s_axi_wdata = 32'h11223344; s_axi_wstrb = 4'h3; s_axi_wvalid = 1; #1;
        vectors++;
        if (s_axi_wready !== 1'b1) begin
            miscompares++; $display("FAIL split_wready: got %b want 1", s_axi_wready);
        end
        @(negedge clk); s_axi_wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            #1; vectors++;
            if ({wb_cyc_o, s_axi_wready} !== 2'b00) begin
                miscompares++; $display("FAIL split_no_cycle: got cyc/wready=%b want 00", {wb_cyc_o, s_axi_wready});
            end
            @(negedge clk);
        end
        s_axi_awaddr = 32'h20; s_axi_awvalid = 1; #1;
        vectors++;
        if (s_axi_awready !== 1'b1) begin
            miscompares++; $display("FAIL split_awready: got %b want 1", s_axi_awready);
        end
        @(negedge clk); s_axi_awvalid = 0;
        wait_b();
    endtask

    task automatic test_read_stall();
        int n = 0;
        sl_wait = 2; sl_rdata = 32'h12345678;
        exp_wb.push_back(mk_wb(0, 32'h08, 0, 4'hF, 3));
        exp_r.push_back(mk_rsp(2'b00, 32'h12345678));
        axi_rd(32'h08);
        #1;
        while (!s_axi_rvalid && n < 50) begin @(negedge clk); #1; n++; end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {1'b1, 2'b00, 32'h12345678}) begin
                miscompares++;
                $display("FAIL r_hold: got v=%b %b/%h want 1 00/12345678", s_axi_rvalid, s_axi_rresp, s_axi_rdata);
            end
            @(negedge clk); #1;
        end
        @(negedge clk);
        wait_r();
        sl_wait = 0;
    endtask

    task automatic test_priority();
        sl_rdata = 32'hCAFEF00D;
        // From reset prio favours writes; a read waiting behind a write must
        // then beat the next write.
        exp_wb.push_back(mk_wb(1, 32'h44, 32'h00000044, 4'hF, 1));
        exp_wb.push_back(mk_wb(0, 32'h40, 0, 4'hF, 1));
        exp_wb.push_back(mk_wb(1, 32'h48, 32'h00000048, 4'hF, 1));
        exp_b.push_back(mk_rsp(2'b00, 0));
        exp_b.push_back(mk_rsp(2'b00, 0));
        exp_r.push_back(mk_rsp(2'b00, 32'hCAFEF00D));
        fork
            begin axi_wr(32'h44, 32'h44, 4'hF); wait_b(); axi_wr(32'h48, 32'h48, 4'hF); wait_b(); end
            begin axi_rd(32'h40); wait_r(); end
        join
        // The last completed transfer was a write, so the read goes first.
        exp_wb.push_back(mk_wb(0, 32'h50, 0, 4'hF, 1));
        exp_wb.push_back(mk_wb(1, 32'h54, 32'h00000054, 4'hF, 1));
        exp_b.push_back(mk_rsp(2'b00, 0));
        exp_r.push_back(mk_rsp(2'b00, 32'hCAFEF00D));
        fork
            begin axi_wr(32'h54, 32'h54, 4'hF); wait_b(); end
            begin axi_rd(32'h50); wait_r(); end
        join
    endtask

    task automatic test_err();
        sl_err = 1; sl_rdata = 32'hBAD0BAD0;
        exp_wb.push_back(mk_wb(0, 32'h0C, 0, 4'hF, 1));
        exp_r.push_back(mk_rsp(2'b10, 32'h0));
        axi_rd(32'h0C);
        wait_r();
        sl_err = 0;
    endtask

`ifdef AXIL2WB_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0, cyc = 0;
        sl_silent = 1;
        exp_b.push_back(mk_rsp(2'b10, 0));
        axi_wr(32'h30, 32'h30, 4'hF);
        #1;
        while (wb_stb_o && n < 50) begin cyc++; @(negedge clk); #1; n++; end
        vectors++;
        if (cyc != 4) begin
            miscompares++; $display("FAIL timeout_stb_len: got %0d want 4", cyc);
        end
        @(negedge clk);
        wait_b();
        sl_silent = 0;
    endtask
`endif

    task automatic test_reset_abort();
        int n = 0;
        sl_silent = 1;
        axi_wr(32'h60, 32'h60, 4'hF);
        #1;
        while (!wb_stb_o && n < 20) begin @(negedge clk); #1; n++; end
        rst_i = 1;
        @(negedge clk); #1;
        vectors++;
        if ({wb_cyc_o, wb_stb_o, s_axi_bvalid} !== 3'b000) begin
            miscompares++; $display("FAIL rst_abort: got cyc/stb/bvalid=%b want 000", {wb_cyc_o, wb_stb_o, s_axi_bvalid});
        end
        rst_i = 0; sl_silent = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1; vectors++;
            if (s_axi_bvalid !== 1'b0) begin
                miscompares++; $display("FAIL rst_no_bvalid: got %b want 0", s_axi_bvalid);
            end
        end
        @(negedge clk);
        sl_rdata = 32'h0BADF00D;
        exp_wb.push_back(mk_wb(0, 32'h70, 0, 4'hF, 1));
        exp_r.push_back(mk_rsp(2'b00, 32'h0BADF00D));
        axi_rd(32'h70);
        wait_r();
    endtask

    initial begin
        test_reset();
        test_write();
        test_split_write();
        test_read_stall();
        test_reset();
        test_priority();
        test_err();
`ifdef AXIL2WB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_abort();
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_wb.size() + exp_b.size() + exp_r.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_wb.size() + exp_b.size() + exp_r.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
